// File: rtl/fw_ram_ctrl.sv
// fw_ram_ctrl: firmware-only RAM built from NUM_BANKS banks of paired 256x16 EBRs.
// Bus access is allowed only in firmware mode; entering application mode zeroises
// every bank (one word per cycle, all banks in parallel).
// Optional feature: define FW_RAM_VIOLATION_EN to implement the sticky
// access_violation flag; otherwise access_violation is tied low.
module fw_ram_ctrl #(
    parameter int unsigned NUM_BANKS = 2,
    localparam int unsigned ADDR_WIDTH = 8 + $clog2(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fw_app_mode,
    input  logic                  cs,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  ready,
    output logic                  scrubbing,
    output logic                  access_violation
);

    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_t;

    state_t            state;
    logic [7:0]        scrub_cnt;
    logic              mode_q;
    logic              rd_valid_q;
    logic [BANK_W-1:0] bank_q;
    logic [BANK_W-1:0] bank_sel;
    logic [31:0]       bank_rd [NUM_BANKS];

    logic mode_rise;
    logic granted;
    logic blocked;
    logic bus_wr;
    logic bus_rd;
    logic scrub_wr;

    // Bank select: high address bits, or bank 0 when there is a single bank
    if (NUM_BANKS > 1) begin : g_bank_sel
        assign bank_sel = address[ADDR_WIDTH-1:8];
    end else begin : g_bank_sel_single
        assign bank_sel = '0;
    end

    // Access qualification; reset gates all EBR writes so a scrub aborts immediately
    assign mode_rise = fw_app_mode & ~mode_q;
    assign granted   = cs & ~fw_app_mode & (state == IDLE);
    assign blocked   = cs & ~granted;
    assign scrub_wr  = (state == SCRUB) & reset_n;
    assign bus_wr    = granted & (we != 4'h0) & reset_n;
    assign bus_rd    = granted & (we == 4'h0) & reset_n;

    // Control FSM: mode edge detect, scrub sequencing, access acknowledge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            scrub_cnt  <= 8'h00;
            mode_q     <= 1'b0;
            scrubbing  <= 1'b0;
            ready      <= 1'b0;
            rd_valid_q <= 1'b0;
            bank_q     <= '0;
        end else begin
            mode_q     <= fw_app_mode;
            ready      <= cs;
            rd_valid_q <= bus_rd;
            if (cs) begin
                bank_q <= bank_sel;
            end
            case (state)
                IDLE: begin
                    if (mode_rise) begin
                        state     <= SCRUB;
                        scrub_cnt <= 8'h00;
                        scrubbing <= 1'b1;
                    end
                end
                SCRUB: begin
                    scrub_cnt <= scrub_cnt + 8'd1;
                    if (scrub_cnt == 8'hFF) begin
                        state     <= IDLE;
                        scrubbing <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    scrubbing <= 1'b0;
                end
            endcase
        end
    end

`ifdef FW_RAM_VIOLATION_EN
    // Sticky flag set by any blocked access, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            access_violation <= 1'b0;
        end else if (blocked) begin
            access_violation <= 1'b1;
        end
    end
`else
    assign access_violation = 1'b0;
    logic unused_blocked;
    assign unused_blocked = blocked;
`endif

    // Bank storage: two 256x16 EBRs per bank, byte-lane writes, registered read port
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [15:0] ebr_lo [256];
        logic [15:0] ebr_hi [256];
        logic [3:0]  lane_we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        rd_en;
        logic [31:0] rd_q;

        // Write port mux: scrub overrides bus writes and hits every bank
        always_comb begin
            lane_we = 4'h0;
            waddr   = address[7:0];
            wdata   = write_data;
            if (scrub_wr) begin
                lane_we = 4'hF;
                waddr   = scrub_cnt;
                wdata   = 32'h0;
            end else if (bus_wr && (bank_sel == BANK_W'(b))) begin
                lane_we = we;
            end
        end

        assign rd_en = bus_rd & (bank_sel == BANK_W'(b));

        // EBR array write and synchronous read
        always_ff @(posedge clk) begin
            if (lane_we[0]) ebr_lo[waddr][7:0]  <= wdata[7:0];
            if (lane_we[1]) ebr_lo[waddr][15:8] <= wdata[15:8];
            if (lane_we[2]) ebr_hi[waddr][7:0]  <= wdata[23:16];
            if (lane_we[3]) ebr_hi[waddr][15:8] <= wdata[31:24];
            if (rd_en) begin
                rd_q <= {ebr_hi[address[7:0]], ebr_lo[address[7:0]]};
            end
        end

        assign bank_rd[b] = rd_q;
    end

    // Read data is steered by the bank captured with cs and is zero unless a granted read completes
    assign read_data = rd_valid_q ? bank_rd[bank_q] : 32'h0;

endmodule

// File: tb/tb_fw_ram_ctrl.sv
// Directed testbench for fw_ram_ctrl (NUM_BANKS=2 and NUM_BANKS=4 instances).
module tb_fw_ram_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fw_app_mode;
    logic        cs;
    logic [3:0]  we;
    logic [8:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        scrubbing;
    logic        access_violation;

    logic        cs4;
    logic [9:0]  address4;
    logic [31:0] read_data4;
    logic        ready4;
    logic        scrubbing4;
    logic        access_violation4;

    int checks = 0;
    int errors = 0;
    int n;
    logic exp_viol;

    always #5 clk = ~clk;

    fw_ram_ctrl #(.NUM_BANKS(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .fw_app_mode(fw_app_mode), .cs(cs), .we(we),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .scrubbing(scrubbing), .access_violation(access_violation)
    );

    fw_ram_ctrl #(.NUM_BANKS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .fw_app_mode(fw_app_mode), .cs(cs4), .we(we),
        .address(address4), .write_data(write_data), .read_data(read_data4),
        .ready(ready4), .scrubbing(scrubbing4), .access_violation(access_violation4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle access on the 2-bank instance; outputs are sampled after return
    task automatic acc(input logic [3:0] w, input logic [8:0] a, input logic [31:0] d);
        cs = 1'b1; we = w; address = a; write_data = d;
        tick();
        cs = 1'b0; we = 4'h0;
    endtask

    task automatic wr(input string tag, input logic [8:0] a, input logic [3:0] w, input logic [31:0] d);
        acc(w, a, d);
        chk(tag, 32'(ready), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [8:0] a, input logic [31:0] exp);
        acc(4'h0, a, 32'h0);
        chk({tag, "_rdy"}, 32'(ready), 32'd1);
        chk(tag, read_data, exp);
    endtask

    task automatic acc4(input logic [3:0] w, input logic [9:0] a, input logic [31:0] d);
        cs4 = 1'b1; we = w; address4 = a; write_data = d;
        tick();
        cs4 = 1'b0; we = 4'h0;
    endtask

    initial begin
`ifdef FW_RAM_VIOLATION_EN
        exp_viol = 1'b1;
`else
        exp_viol = 1'b0;
`endif
        reset_n = 1'b0; fw_app_mode = 1'b0; cs = 1'b0; we = 4'h0; address = '0;
        write_data = '0; cs4 = 1'b0; address4 = '0;
        repeat (2) tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_scrub", 32'(scrubbing), 32'd0);
        chk("rst_viol", 32'(access_violation), 32'd0);
        reset_n = 1'b1;
        tick();

        // Bank isolation and read timing
        wr("wr_005", 9'h005, 4'hF, 32'h01234567);
        wr("wr_105", 9'h105, 4'hF, 32'hDEADBEEF);
        tick();
        chk("idle_ready", 32'(ready), 32'd0);
        chk("idle_rdata", read_data, 32'h0);
        cs = 1'b1; we = 4'h0; address = 9'h105;
        tick();
        cs = 1'b0; address = 9'h005;
        #1;
        chk("rd_105_rdy", 32'(ready), 32'd1);
        chk("rd_105_bank_held", read_data, 32'hDEADBEEF);
        rd_chk("rd_005_isol", 9'h005, 32'h01234567);
        tick();
        chk("after_rd_ready", 32'(ready), 32'd0);

        // Byte-lane write
        wr("wr_010", 9'h010, 4'hF, 32'h11223344);
        wr("wr_010_lanes", 9'h010, 4'b0101, 32'hAABBCCDD);
        rd_chk("rd_010_lanes", 9'h010, 32'h11BB33DD);

        // Zeroisation of every bank
        wr("fill_000", 9'h000, 4'hF, 32'hFFFFFFFF);
        wr("fill_080", 9'h080, 4'hF, 32'hFFFFFFFF);
        wr("fill_0ff", 9'h0FF, 4'hF, 32'hFFFFFFFF);
        wr("fill_100", 9'h100, 4'hF, 32'hFFFFFFFF);
        wr("fill_180", 9'h180, 4'hF, 32'hFFFFFFFF);
        wr("fill_1ff", 9'h1FF, 4'hF, 32'hFFFFFFFF);
        rd_chk("rd_1ff_fill", 9'h1FF, 32'hFFFFFFFF);
        fw_app_mode = 1'b1;
        tick();
        chk("scrub_start", 32'(scrubbing), 32'd1);
        n = 0;
        while (scrubbing === 1'b1 && n < 400) begin
            if (n == 10) begin
                fw_app_mode = 1'b0; cs = 1'b1; we = 4'hF; address = 9'h000;
                write_data = 32'hA5A5A5A5;
            end else begin
                cs = 1'b0; we = 4'h0;
            end
            if (n == 11) begin
                chk("scrub_blk_ready", 32'(ready), 32'd1);
                chk("scrub_blk_rdata", read_data, 32'h0);
            end
            n++;
            tick();
        end
        cs = 1'b0; we = 4'h0;
        chk("scrub_len", 32'(n), 32'd256);
        tick();
        chk("no_scrub_on_fall", 32'(scrubbing), 32'd0);
        rd_chk("z_000", 9'h000, 32'h0);
        rd_chk("z_080", 9'h080, 32'h0);
        rd_chk("z_0ff", 9'h0FF, 32'h0);
        rd_chk("z_100", 9'h100, 32'h0);
        rd_chk("z_180", 9'h180, 32'h0);
        rd_chk("z_1ff", 9'h1FF, 32'h0);
        chk("viol_after_scrub_cs", 32'(access_violation), 32'(exp_viol));

        // Blocked write in application mode
        fw_app_mode = 1'b1;
        tick();
        n = 0;
        while (scrubbing === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        chk("scrub2_len", 32'(n), 32'd256);
        acc(4'hF, 9'h020, 32'h12345678);
        chk("app_blk_ready", 32'(ready), 32'd1);
        chk("app_blk_rdata", read_data, 32'h0);
        chk("app_viol", 32'(access_violation), 32'(exp_viol));
        fw_app_mode = 1'b0;
        tick();
        rd_chk("rd_020_kept", 9'h020, 32'h0);

        // Reset aborts a scrub part-way
        wr("pre_050", 9'h050, 4'hF, 32'hFFFFFFFF);
        wr("pre_063", 9'h063, 4'hF, 32'hFFFFFFFF);
        wr("pre_064", 9'h064, 4'hF, 32'h77777777);
        wr("pre_0c8", 9'h0C8, 4'hF, 32'hCAFEF00D);
        fw_app_mode = 1'b1;
        tick();
        chk("scrub3_start", 32'(scrubbing), 32'd1);
        repeat (100) tick();
        chk("scrub3_c100", 32'(scrubbing), 32'd1);
        reset_n = 1'b0; fw_app_mode = 1'b0;
        tick();
        chk("abort_scrub", 32'(scrubbing), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_viol", 32'(access_violation), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("abort_idle", 32'(scrubbing), 32'd0);
        rd_chk("ab_050", 9'h050, 32'h0);
        rd_chk("ab_063", 9'h063, 32'h0);
        rd_chk("ab_064", 9'h064, 32'h77777777);
        rd_chk("ab_0c8", 9'h0C8, 32'hCAFEF00D);

        // Four-bank instance
        acc4(4'hF, 10'h0FF, 32'h0B0B0B00);
        acc4(4'hF, 10'h1FF, 32'h1B1B1B11);
        acc4(4'hF, 10'h2FF, 32'h2B2B2B22);
        acc4(4'hF, 10'h3FF, 32'h3B3B3B33);
        acc4(4'h0, 10'h0FF, 32'h0);
        chk("b4_0ff_rdy", 32'(ready4), 32'd1);
        chk("b4_0ff", read_data4, 32'h0B0B0B00);
        acc4(4'h0, 10'h1FF, 32'h0);
        chk("b4_1ff_rdy", 32'(ready4), 32'd1);
        chk("b4_1ff", read_data4, 32'h1B1B1B11);
        acc4(4'h0, 10'h2FF, 32'h0);
        chk("b4_2ff_rdy", 32'(ready4), 32'd1);
        chk("b4_2ff", read_data4, 32'h2B2B2B22);
        acc4(4'h0, 10'h3FF, 32'h0);
        chk("b4_3ff_rdy", 32'(ready4), 32'd1);
        chk("b4_3ff", read_data4, 32'h3B3B3B33);
        tick();
        chk("b4_idle_ready", 32'(ready4), 32'd0);

        // Application mode held through reset release starts a scrub
        reset_n = 1'b0; fw_app_mode = 1'b1;
        tick();
        chk("rst_hold_scrub", 32'(scrubbing), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rel_scrub", 32'(scrubbing), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
